spm_unit: RTL and testbench

SPM_UNIT -- requirements
Module: spm_unit

---
 rtl/spm_pkg.sv | 17 +
 rtl/spm_cell.sv | 60 ++++++
 rtl/spm_unit.sv | 146 ++++++++++++++
 tb/tb_spm_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// spm_pkg: shared definitions for the serial/parallel multiplier.
//   spm_state_e : controller states (IDLE, RUN, DONE)
//   spm_cnt_w   : cycle-counter width for a given operand width
package spm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } spm_state_e;

  // Counter must hold 0 .. 2*width (RUN cycles) with headroom so it never wraps.
  function automatic int spm_cnt_w(input int width);
    return $clog2(2 * width + 2);
  endfunction

endpackage

// File: rtl/spm_cell.sv
// spm_cell: one carry-save column of the bit-serial multiplier array.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous clear of sum and carry
//   en        : advance the column by one step
//   neg       : two's-complement column mode (partial product negated)
//   x_bit     : this column's multiplicand bit
//   y_bit     : current serial multiplier bit
//   s_in      : sum bit from the next-higher column (or injected bit)
//   s_out     : registered sum bit of this column
module spm_cell (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic neg,
  input  logic x_bit,
  input  logic y_bit,
  input  logic s_in,
  output logic s_out
);

  logic       r_sum;
  logic       r_carry;
  logic       w_pp;
  logic [1:0] w_total;

  // Partial product; in negative mode -pp is formed as ~pp - 1, and the
  // constant -1 terms are compensated by a single bit injected at the top
  // column on the first RUN cycle.
  always_comb begin
    w_pp = x_bit & y_bit;
    if (neg) begin
      w_pp = ~(x_bit & y_bit);
    end else begin
      w_pp = x_bit & y_bit;
    end
    w_total = {1'b0, w_pp} + {1'b0, s_in} + {1'b0, r_carry};
  end

  // Sum/carry storage: the carry stays in this column, the sum moves down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= 1'b0;
      r_carry <= 1'b0;
    end else if (clr) begin
      r_sum   <= 1'b0;
      r_carry <= 1'b0;
    end else if (en) begin
      r_carry <= w_total[1];
      r_sum   <= w_total[0];
    end else begin
      r_sum   <= r_sum;
      r_carry <= r_carry;
    end
  end

  assign s_out = r_sum;

endmodule

// File: rtl/spm_unit.sv
// spm_unit: serial/parallel multiplier. x is applied in parallel to a
// carry-save array, y is fed LSB-first (sign/zero extended to 2*WIDTH bits),
// and the product emerges one bit per cycle into p from the MSB side.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready only in IDLE)
//   x, y, is_signed     : operands, captured on accept
//   out_valid/out_ready : product handshake (out_valid only in DONE)
//   p                   : 2*WIDTH-bit product, held until the next accept
//   busy                : high in RUN or DONE
module spm_unit
  import spm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int              PW       = 2 * WIDTH;
  localparam int              CW       = spm_cnt_w(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(PW);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  spm_state_e        r_state;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_x;
  logic [PW-1:0]     r_y;
  logic              r_signed;
  logic [PW-1:0]     r_p;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;

  logic              w_accept;
  logic              w_run;
  logic              w_inj;
  logic [WIDTH-1:0]  w_s;

  assign w_accept = in_valid & r_in_ready;
  assign w_run    = (r_state == ST_RUN);
  // Compensation bit for the negated MSB column, weight 2^(WIDTH-1).
  assign w_inj    = r_signed & (r_cnt == {CW{1'b0}});

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      logic w_s_in;
      logic w_neg;
      if (gi == WIDTH - 1) begin : g_msb
        assign w_s_in = w_inj;
        assign w_neg  = r_signed;
      end else begin : g_low
        assign w_s_in = w_s[gi+1];
        assign w_neg  = 1'b0;
      end
      spm_cell u_cell (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_accept),
        .en    (w_run),
        .neg   (w_neg),
        .x_bit (r_x[gi]),
        .y_bit (r_y[0]),
        .s_in  (w_s_in),
        .s_out (w_s[gi])
      );
    end
  endgenerate

  // Controller: state, counter, operand capture, product shift, handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {CW{1'b0}};
      r_x         <= {WIDTH{1'b0}};
      r_y         <= {PW{1'b0}};
      r_signed    <= 1'b0;
      r_p         <= {PW{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_x        <= x;
            // y is stored pre-extended so the serial stream is just r_y[0].
            r_y        <= is_signed ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
            r_signed   <= is_signed;
            r_cnt      <= {CW{1'b0}};
            r_p        <= {PW{1'b0}};
            r_state    <= ST_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // 2*WIDTH+1 shifts: the first bit out of the cleared array is a
          // dummy zero that falls off p[0] by the last (flush) cycle.
          r_p <= {w_s[0], r_p[PW-1:1]};
          r_y <= {1'b0, r_y[PW-1:1]};
          if (r_cnt == CNT_LAST) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign p         = r_p;

endmodule

// File: tb/tb_spm_unit.sv
module tb_spm_unit;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           is_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;
  logic           busy;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0]  VA [0:5] = '{8'd50,   8'hFF,    8'h80,    8'h7F,    8'h00,    8'hFF};
  localparam logic [7:0]  VB [0:5] = '{8'hCE,   8'hFF,    8'h80,    8'h80,    8'hFF,    8'hFF};
  localparam logic        VS [0:5] = '{1'b1,    1'b0,     1'b1,     1'b1,     1'b0,     1'b1};
  localparam logic [15:0] VP [0:5] = '{16'hF63C, 16'hFE01, 16'h4000, 16'hC080, 16'h0000, 16'h0001};

  always #5 clk = ~clk;

  spm_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  task automatic wait_ready(output bit to);
    int n;
    n  = 0;
    to = 1'b0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    to = (in_ready !== 1'b1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // One complete operation; operands are scrambled right after the accept edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [15:0] prod, output int lat, output bit to);
    bit t1;
    wait_ready(t1);
    x = a; y = b; is_signed = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; x = ~a; y = b ^ 8'h5A; is_signed = ~s;
    wait_valid(lat);
    to   = t1 || (out_valid !== 1'b1);
    prod = p;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = 8'h00; y = 8'h00; is_signed = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (p !== 16'h0000) begin errors++; $display("FAIL reset_p: got %h expected 0000", p); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_release: in_ready %b busy %b expected 1 0", in_ready, busy); end
  endtask

  task automatic test_vectors();
    logic [15:0] prod;
    int lat;
    bit to;
    for (int i = 0; i < 6; i++) begin
      run_op(VA[i], VB[i], VS[i], prod, lat, to);
      checks++; if (to) begin errors++; $display("FAIL vec%0d_timeout: out_valid %b expected 1", i, out_valid); end
      checks++; if (prod !== VP[i]) begin errors++; $display("FAIL vec%0d_product: got %h expected %h", i, prod, VP[i]); end
      checks++; if (lat != 17) begin errors++; $display("FAIL vec%0d_latency: got %0d expected 17", i, lat); end
    end
  endtask

  task automatic test_stall();
    bit to;
    int lat;
    wait_ready(to);
    x = 8'd3; y = 8'd5; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_reach_done: out_valid %b expected 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (p !== 16'd15 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: p %h ov %b ir %b busy %b expected 000f 1 0 1", i, p, out_valid, in_ready, busy);
      end
      if (i == 2) begin in_valid = 1'b1; x = 8'd9; y = 8'd9; end
      if (i == 3) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: ov %b ir %b expected 0 1", out_valid, in_ready); end
    repeat (2) @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_no_queue: busy %b expected 0", busy); end
    checks++; if (p !== 16'd15) begin errors++; $display("FAIL stall_idle_hold: got %h expected 000f", p); end
  endtask

  task automatic test_reset_mid_run();
    bit to;
    int lat;
    wait_ready(to);
    x = 8'd100; y = 8'd100; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_running: busy %b expected 1", busy); end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_outputs: ir %b ov %b busy %b p %h expected 1 0 0 0000", in_ready, out_valid, busy, p);
    end
    @(posedge clk); #1;
    x = 8'd3; y = 8'd7; is_signed = 1'b0; in_valid = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL midrst_accept: busy %b ir %b expected 1 0", busy, in_ready); end
    wait_valid(lat);
    checks++; if (p !== 16'd21 || lat != 17) begin errors++; $display("FAIL midrst_product: p %h lat %0d expected 0015 17", p, lat); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit to;
    int lat;
    wait_ready(to);
    x = 8'd6; y = 8'd7; is_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    x = 8'd9; y = 8'd11;
    wait_valid(lat);
    checks++; if (p !== 16'd42 || lat != 17) begin errors++; $display("FAIL b2b_first: p %h lat %0d expected 002a 17", p, lat); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_handshake: ir %b ov %b busy %b expected 1 0 0", in_ready, out_valid, busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: busy %b ir %b expected 1 0", busy, in_ready); end
    in_valid = 1'b0;
    wait_valid(lat);
    checks++; if (p !== 16'd99 || lat != 17) begin errors++; $display("FAIL b2b_second: p %h lat %0d expected 0063 17", p, lat); end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0]  a, b;
    logic        s;
    logic [15:0] ea, eb, exp_p, prod;
    int          lat;
    bit          to;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      s = 1'($urandom_range(0, 1));
      ea = s ? {{8{a[7]}}, a} : {8'h00, a};
      eb = s ? {{8{b[7]}}, b} : {8'h00, b};
      exp_p = ea * eb;
      run_op(a, b, s, prod, lat, to);
      checks++;
      if (to || prod !== exp_p) begin
        errors++;
        $display("FAIL rand%0d: x %h y %h s %b got %h expected %h timeout %b", i, a, b, s, prod, exp_p, to);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
